// File: rtl/sram_pkg.sv
// sram_pkg: shared types and constants for the SRAM responder.
//   state_e    - responder FSM states
//   pins_t     - one sample of the controller-side SRAM pins
//   PINS_IDLE  - pin sample with all strobes inactive (synchroniser reset value)
package sram_pkg;

  localparam int          SRAM_ADDR_W = 18;
  localparam int          SRAM_DATA_W = 16;
  localparam logic [15:0] BOUNDS_FILL = 16'hDEAD;

  typedef enum logic [2:0] {
    IDLE,
    WRITE_ACTIVE,
    WRITE_COMMIT,
    READ_WAIT,
    READ_DRIVE
  } state_e;

  typedef struct packed {
    logic                   en_n;
    logic                   oe_n;
    logic                   we_n;
    logic [SRAM_ADDR_W-1:0] addr;
    logic [SRAM_DATA_W-1:0] data;
  } pins_t;

  localparam pins_t PINS_IDLE = '{en_n: 1'b1, oe_n: 1'b1, we_n: 1'b1,
                                  addr: '0, data: '0};

endpackage

// File: rtl/sram_pin_sync.sv
// sram_pin_sync: two-flop synchroniser for the asynchronous SRAM pins.
// Strobes, address and data travel through the same two stages so the
// sampled address/data stay aligned with the sampled strobes.
//   clk, rst_n - clock, async active-low reset (strobes reset inactive)
//   pins_i     - raw pin sample
//   pins_o     - synchronised pin sample
module sram_pin_sync
  import sram_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  pins_t pins_i,
  output pins_t pins_o
);

  pins_t meta_q, meta_d;
  pins_t sync_q, sync_d;

  always_comb begin
    meta_d = pins_i;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= PINS_IDLE;
      sync_q <= PINS_IDLE;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign pins_o = sync_q;

endmodule

// File: rtl/sram_responder.sv
// sram_responder: emulates the memory-chip end of a 16-bit asynchronous
// SRAM so an SRAM controller can be exercised without the real part.
// Strobes are sampled on CLK1; writes are committed into an internal word
// array, reads are served after READ_LAT cycles.
//   CLK1, RST         - clock, async active-low reset
//   Ram_EN/OE/WE      - active-low chip/output/write enables
//   Ram_address       - 18-bit word address (low ADDR_W bits implemented)
//   Ram_data          - bidirectional data, driven only in READ_DRIVE
//   wr_count/rd_count - committed writes / read accesses since reset
//   last_wdata        - data of the most recent committed write
//   proto_err         - sticky protocol-error flag
// Optional: define SRAM_RESP_BOUNDS_EN to reject addresses with nonzero bits
// above ADDR_W (writes dropped, reads return BOUNDS_FILL, proto_err set);
// otherwise those bits are ignored and addresses alias.
module sram_responder
  import sram_pkg::*;
#(
  parameter int ADDR_W   = 10,
  parameter int READ_LAT = 2,
  parameter int CNT_W    = 16
) (
  input  logic                   CLK1,
  input  logic                   RST,
  input  logic                   Ram_EN,
  input  logic                   Ram_OE,
  input  logic                   Ram_WE,
  input  logic [SRAM_ADDR_W-1:0] Ram_address,
  inout  wire  [SRAM_DATA_W-1:0] Ram_data,
  output logic [CNT_W-1:0]       wr_count,
  output logic [CNT_W-1:0]       rd_count,
  output logic [SRAM_DATA_W-1:0] last_wdata,
  output logic                   proto_err
);

  localparam logic [2:0] LAT_END = 3'(READ_LAT);

  pins_t pins_raw, s;

  assign pins_raw = '{en_n: Ram_EN, oe_n: Ram_OE, we_n: Ram_WE,
                      addr: Ram_address, data: Ram_data};

  sram_pin_sync u_sync (
    .clk    (CLK1),
    .rst_n  (RST),
    .pins_i (pins_raw),
    .pins_o (s)
  );

  logic [ADDR_W-1:0] sidx;
  logic              s_oob;
  assign sidx = s.addr[ADDR_W-1:0];

`ifdef SRAM_RESP_BOUNDS_EN
  assign s_oob = |s.addr[SRAM_ADDR_W-1:ADDR_W];
`else
  logic addr_hi_unused;
  assign addr_hi_unused = |s.addr[SRAM_ADDR_W-1:ADDR_W];
  assign s_oob = 1'b0;
`endif

  state_e                 state_q, state_d;
  logic [2:0]             lat_q, lat_d;
  logic [ADDR_W-1:0]      widx_q, widx_d, ridx_q, ridx_d;
  logic [SRAM_DATA_W-1:0] wdata_q, wdata_d, last_q, last_d;
  logic                   woob_q, woob_d;
  logic [CNT_W-1:0]       wr_q, wr_d, rd_q, rd_d;
  logic                   err_q, err_d;
  logic                   hold, mem_we, rd_en, wr_strobe, rd_strobe;

  logic [SRAM_DATA_W-1:0] mem [2**ADDR_W];
  logic [SRAM_DATA_W-1:0] rdata_q;

  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    widx_d  = widx_q;
    wdata_d = wdata_q;
    woob_d  = woob_q;
    ridx_d  = ridx_q;
    last_d  = last_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    err_d   = err_q;
    hold    = 1'b0;
    mem_we  = 1'b0;
    rd_en   = 1'b0;

    wr_strobe = !s.en_n && !s.we_n;
    rd_strobe = !s.en_n && !s.oe_n;
    // OE and WE low together is a controller bug whatever state we are in.
    if (wr_strobe && !s.oe_n) err_d = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (wr_strobe) begin
          state_d = WRITE_ACTIVE;
          hold    = 1'b1;
        end else if (rd_strobe) begin
          state_d = READ_WAIT;
          rd_d    = rd_q + CNT_W'(1);
          rd_en   = 1'b1;
          lat_d   = 3'd1;
        end
      end
      WRITE_ACTIVE: begin
        // Keep the last sample taken while the strobe was still low.
        if (wr_strobe) hold    = 1'b1;
        else           state_d = WRITE_COMMIT;
      end
      WRITE_COMMIT: begin
        mem_we  = !woob_q;
        last_d  = wdata_q;
        wr_d    = wr_q + CNT_W'(1);
        if (woob_q) err_d = 1'b1;
        state_d = IDLE;
      end
      READ_WAIT: begin
        if (wr_strobe) begin
          state_d = WRITE_ACTIVE;
          hold    = 1'b1;
        end else if (!rd_strobe) begin
          state_d = IDLE;
        end else if (lat_q == LAT_END) begin
          state_d = READ_DRIVE;
        end else begin
          lat_d = lat_q + 3'd1;
        end
      end
      READ_DRIVE: begin
        if (wr_strobe) begin
          state_d = WRITE_ACTIVE;
          hold    = 1'b1;
        end else if (!rd_strobe) begin
          state_d = IDLE;
        end else if (sidx != ridx_q) begin
          rd_en = 1'b1;   // address moved under an open read: fetch again
        end
      end
      default: state_d = IDLE;
    endcase

    if (hold) begin
      widx_d  = sidx;
      wdata_d = s.data;
      woob_d  = s_oob;
    end
    if (rd_en) begin
      ridx_d = sidx;
      if (s_oob) err_d = 1'b1;
    end
  end

  always_ff @(posedge CLK1 or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      lat_q   <= '0;
      widx_q  <= '0;
      wdata_q <= '0;
      woob_q  <= 1'b0;
      ridx_q  <= '0;
      last_q  <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      widx_q  <= widx_d;
      wdata_q <= wdata_d;
      woob_q  <= woob_d;
      ridx_q  <= ridx_d;
      last_q  <= last_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      err_q   <= err_d;
    end
  end

  // Array and its read register carry no reset so they map onto block RAM.
  always_ff @(posedge CLK1) begin
    if (mem_we) mem[widx_q] <= wdata_q;
    if (rd_en)  rdata_q     <= s_oob ? BOUNDS_FILL : mem[sidx];
  end

  assign Ram_data   = (state_q == READ_DRIVE) ? rdata_q : {SRAM_DATA_W{1'bz}};
  assign wr_count   = wr_q;
  assign rd_count   = rd_q;
  assign last_wdata = last_q;
  assign proto_err  = err_q;

endmodule

// File: tb/tb_sram_responder.sv
module tb_sram_responder;

  localparam int AW = 10;
  localparam int RL = 2;
  localparam int CW = 16;
`ifdef SRAM_RESP_BOUNDS_EN
  localparam bit BOUNDS = 1'b1;
`else
  localparam bit BOUNDS = 1'b0;
`endif

  localparam int E_WR = 0, E_RD = 1, E_ON = 2, E_VAL = 3, E_OFF = 4,
                 E_ERR = 5, E_RST = 6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b1, oe = 1'b1, we = 1'b1;
  logic [17:0] addr = '0;
  logic [15:0] tb_wdata = '0;
  logic        tb_drv = 1'b0;
  wire  [15:0] ram_data;
  logic [CW-1:0] wr_count, rd_count;
  logic [15:0] last_wdata;
  logic        proto_err;

  assign ram_data = tb_drv ? tb_wdata : 16'hzzzz;

  sram_responder #(.ADDR_W(AW), .READ_LAT(RL), .CNT_W(CW)) dut (
    .CLK1        (clk),
    .RST         (rst_n),
    .Ram_EN      (en),
    .Ram_OE      (oe),
    .Ram_WE      (we),
    .Ram_address (addr),
    .Ram_data    (ram_data),
    .wr_count    (wr_count),
    .rd_count    (rd_count),
    .last_wdata  (last_wdata),
    .proto_err   (proto_err)
  );

  always #10 clk = ~clk;

  // ---------------- reference model ----------------
  // Expected output changes are queued with the cycle at which they become
  // visible, derived from the pin-timing rules (2-flop sampling, 3-cycle
  // commit, 2+READ_LAT read latency, release 2 cycles after sampled rise).
  typedef struct { int t; int k; int a; int v; } ev_t;
  ev_t evq[$];

  logic [15:0] mm [1024];
  int          m_wr = 0, m_rd = 0;
  logic [15:0] m_last = '0, m_val = '0;
  bit          m_err = 1'b0, m_drv = 1'b0;

  int cyc = 0, n_cmp = 0, n_bad = 0;

  function automatic void push(input int t, input int k, input int a, input int v);
    ev_t e;
    e.t = t; e.k = k; e.a = a; e.v = v;
    evq.push_back(e);
  endfunction

  function automatic bit oob(input int a);
    return BOUNDS && ((a >> AW) != 0);
  endfunction

  function automatic logic [15:0] word_of(input int a);
    return oob(a) ? 16'hDEAD : mm[a % 1024];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_rel(input string nm);
    n_cmp++;
    if (!($isunknown(ram_data) || ram_data === 16'h0000)) begin
      n_bad++;
      $display("FAIL %s: bus shows %h, required released (cycle %0d)", nm, ram_data, cyc);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    #2;
    for (int i = 0; i < evq.size(); ) begin
      if (evq[i].t <= cyc) begin
        ev_t e;
        e = evq[i];
        case (e.k)
          E_WR: begin
            m_wr++;
            m_last = e.v[15:0];
            if (oob(e.a)) m_err = 1'b1;
            else          mm[e.a % 1024] = e.v[15:0];
          end
          E_RD:  begin m_rd++; if (oob(e.a)) m_err = 1'b1; end
          E_ON:  begin m_drv = 1'b1; m_val = word_of(e.a); end
          E_VAL: m_val = word_of(e.a);
          E_OFF: m_drv = 1'b0;
          E_ERR: m_err = 1'b1;
          E_RST: begin m_wr = 0; m_rd = 0; m_last = '0; m_err = 1'b0; m_drv = 1'b0; end
          default: ;
        endcase
        evq.delete(i);
      end else begin
        i++;
      end
    end
    chk("wr_count",   32'(wr_count),   32'(m_wr[CW-1:0]));
    chk("rd_count",   32'(rd_count),   32'(m_rd[CW-1:0]));
    chk("last_wdata", 32'(last_wdata), 32'(m_last));
    chk("proto_err",  32'(proto_err),  32'(m_err));
    if (m_drv)       chk("bus_read", 32'(ram_data), 32'(m_val));
    else if (tb_drv) chk("bus_wr",   32'(ram_data), 32'(tb_wdata));
    else             chk_rel("bus_idle");
  end

  // ---------------- stimulus ----------------
  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic idle_pins();
    en = 1'b1; oe = 1'b1; we = 1'b1; tb_drv = 1'b0;
  endtask

  task automatic do_write(input int a, input int d, input int hold, input bit oe_too);
    int c0;
    c0 = cyc;
    addr = 18'(a); tb_wdata = 16'(d); tb_drv = 1'b1;
    en = 1'b0; we = 1'b0; oe = !oe_too;
    if (oe_too) push(c0 + 3, E_ERR, 0, 0);
    wait_cyc(hold);
    idle_pins();
    push(cyc + 4, E_WR, a, d);
    wait_cyc(5);
  endtask

  // chg_off >= 0 moves the address to a2 that many cycles after OE falls;
  // pin >= 0 additionally pins the first driven word to that literal.
  task automatic do_read(input int a, input int hold, input int chg_off,
                         input int a2, input int pin);
    int c0, d, rel;
    c0 = cyc;
    addr = 18'(a); en = 1'b0; oe = 1'b0; we = 1'b1;
    push(c0 + 3, E_RD, a, 0);
    d   = c0 + 3 + RL;
    rel = c0 + hold + 3;
    if (d < rel) begin
      push(d, E_ON, a, 0);
      push(rel, E_OFF, 0, 0);
    end
    for (int k = 0; k < hold; k++) begin
      if (k == chg_off) begin
        addr = 18'(a2);
        push(c0 + k + 3, E_VAL, a2, 0);
      end
      if (pin >= 0 && k == 2 + RL) chk_rel("pin_pre_drive");
      if (pin >= 0 && k == 3 + RL) chk("pin_read", 32'(ram_data), 32'(pin));
      @(negedge clk);
    end
    idle_pins();
    wait_cyc(5);
  endtask

  int waddrs[$];

  initial begin
    int a, a2, r, h, co;
    wait_cyc(3);
    chk("rst_wr", 32'(wr_count), 32'd0);
    chk("rst_rd", 32'(rd_count), 32'd0);
    chk("rst_last", 32'(last_wdata), 32'd0);
    chk("rst_err", 32'(proto_err), 32'd0);
    chk_rel("rst_bus");
    rst_n = 1'b1;
    wait_cyc(3);

    // single write / read
    do_write(5, 16'h1234, 4, 1'b0);
    chk("w1_count", 32'(wr_count), 32'd1);
    chk("w1_last", 32'(last_wdata), 32'h1234);
    do_read(5, 8, -1, 0, 16'h1234);
    chk("r1_count", 32'(rd_count), 32'd1);

    // burst
    for (int i = 0; i < 10; i++) do_write(16'h100 + i, 16'h10 + i, 2, 1'b0);
    for (int i = 0; i < 10; i++) do_read(16'h100 + i, 8, -1, 0, 16'h10 + i);
    chk("burst_wr", 32'(wr_count), 32'd11);
    chk("burst_rd", 32'(rd_count), 32'd11);

    // OE and WE low together: write wins, error sticks
    do_write(3, 16'hBEEF, 3, 1'b1);
    chk("both_err", 32'(proto_err), 32'd1);
    do_read(3, 8, -1, 0, 16'hBEEF);
    chk("both_err_held", 32'(proto_err), 32'd1);

    // reset in the middle of a write
    do_write(16'h077, 16'hAAAA, 2, 1'b0);
    addr = 18'h077; tb_wdata = 16'h5555; tb_drv = 1'b1; en = 1'b0; we = 1'b0;
    wait_cyc(4);
    rst_n = 1'b0;
    push(cyc + 1, E_RST, 0, 0);
    #1;
    chk("mid_rst_wr", 32'(wr_count), 32'd0);
    chk("mid_rst_err", 32'(proto_err), 32'd0);
    chk("mid_rst_last", 32'(last_wdata), 32'd0);
    idle_pins();
    wait_cyc(2);
    rst_n = 1'b1;
    wait_cyc(3);
    do_read(16'h077, 8, -1, 0, 16'hAAAA);
    chk("post_rst_rd", 32'(rd_count), 32'd1);

    // upper address bits
    do_write(18'h00400, 16'h7777, 2, 1'b0);
    do_read(18'h00400, 8, -1, 0, BOUNDS ? 16'hDEAD : 16'h7777);
    chk("hi_addr_err", 32'(proto_err), 32'(BOUNDS));
    if (!BOUNDS) do_read(0, 8, -1, 0, 16'h7777);

    waddrs.push_back(5); waddrs.push_back(3); waddrs.push_back(16'h077);
    for (int i = 0; i < 10; i++) waddrs.push_back(16'h100 + i);

    // randomized traffic
    for (int n = 0; n < 80; n++) begin
      r = $urandom_range(0, 9);
      if (r < 4) begin
        a = BOUNDS ? int'($urandom_range(0, 1023)) : int'($urandom & 32'h3FFFF);
        do_write(a, int'($urandom & 32'hFFFF), $urandom_range(1, 5),
                 $urandom_range(0, 7) == 0);
        waddrs.push_back(a);
      end else if (r < 8) begin
        a = waddrs[$urandom_range(0, waddrs.size() - 1)];
        do_read(a, $urandom_range(1, 8), -1, 0, -1);
      end else begin
        a  = waddrs[$urandom_range(0, waddrs.size() - 1)];
        a2 = waddrs[$urandom_range(0, waddrs.size() - 1)];
        co = RL + 1 + $urandom_range(0, 2);
        h  = co + 2 + $urandom_range(0, 3);
        do_read(a, h, co, a2, -1);
      end
    end

    wait_cyc(4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
